// File: rtl/tmds_channel_decoder.sv
// TMDS receive channel decoder: bit-slip alignment on control-token runs, then video/control/TERC4 decode.
// Define TMDS_DEC_TERC4_EN to compile in the TERC4 code table; otherwise terc4/terc4_hit read 0.
module tmds_channel_decoder #(
    parameter int CTRL_RUN_MIN = 8,
    parameter int TRY_CYCLES   = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic       clk_pix,
    input  logic       rst_in,
    input  logic [9:0] sym_in,
    output logic       locked,
    output logic [3:0] bit_offset,
    output logic       de,
    output logic [1:0] ctrl,
    output logic [7:0] data,
    output logic [3:0] terc4,
    output logic       terc4_hit
);
    localparam int RUN_W  = $clog2(CTRL_RUN_MIN) + 1;
    localparam int TRY_W  = $clog2(TRY_CYCLES) + 1;
    localparam int IDLE_W = $clog2(LOCK_TIMEOUT) + 1;
    localparam logic [RUN_W-1:0]  RUN_LAST = RUN_W'(CTRL_RUN_MIN - 1);
    localparam logic [TRY_W-1:0]  TRY_LAST = TRY_W'(TRY_CYCLES - 1);
    localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(LOCK_TIMEOUT);

    typedef enum logic {SEARCH, LOCKED} state_e;

    state_e            state_q;
    logic [3:0]        off_q;
    logic [RUN_W-1:0]  run_q;
    logic [TRY_W-1:0]  try_q;
    logic [IDLE_W-1:0] idle_q;
    logic [1:0]        flush_q;
    logic [9:0]        sym_d_q;
    logic [9:0]        aw_q;
    logic              de_q;
    logic [1:0]        ctrl_q;
    logic [7:0]        data_q;

    logic [19:0] window;
    logic [4:0]  off_ext;
    logic [9:0]  aw_d;
    logic        tok_d;
    logic [1:0]  tok_ctrl_d;
    logic [7:0]  dw;
    logic [7:0]  vid_d;

    assign window  = {sym_in, sym_d_q};
    assign off_ext = {1'b0, off_q};
    assign aw_d    = window[off_ext +: 10];

    always_ff @(posedge clk_pix or posedge rst_in) begin
        if (rst_in) begin
            sym_d_q <= '0;
            aw_q    <= '0;
        end else begin
            sym_d_q <= sym_in;
            aw_q    <= aw_d;
        end
    end

    always_comb begin
        tok_d      = 1'b1;
        tok_ctrl_d = 2'b00;
        case (aw_q)
            10'h354: tok_ctrl_d = 2'b00;
            10'h0AB: tok_ctrl_d = 2'b01;
            10'h154: tok_ctrl_d = 2'b10;
            10'h2AB: tok_ctrl_d = 2'b11;
            default: tok_d = 1'b0;
        endcase
    end

    // Undo the optional inversion, then the XOR/XNOR transition chain.
    always_comb begin
        dw       = aw_q[9] ? ~aw_q[7:0] : aw_q[7:0];
        vid_d    = '0;
        vid_d[0] = dw[0];
        for (int i = 1; i < 8; i++)
            vid_d[i] = aw_q[8] ? (dw[i] ^ dw[i-1]) : ~(dw[i] ^ dw[i-1]);
    end

    always_ff @(posedge clk_pix or posedge rst_in) begin
        if (rst_in) begin
            state_q <= SEARCH;
            off_q   <= '0;
            run_q   <= '0;
            try_q   <= '0;
            idle_q  <= '0;
            flush_q <= '0;
        end else begin
            case (state_q)
                SEARCH: begin
                    // A lock in the same cycle as try expiry keeps the current offset.
                    if (flush_q == 2'd0 && tok_d && run_q >= RUN_LAST) begin
                        state_q <= LOCKED;
                        run_q   <= '0;
                        try_q   <= '0;
                        idle_q  <= '0;
                    end else if (try_q >= TRY_LAST) begin
                        off_q   <= (off_q == 4'd9) ? 4'd0 : off_q + 4'd1;
                        run_q   <= '0;
                        try_q   <= '0;
                        flush_q <= 2'd2;
                    end else begin
                        try_q <= try_q + TRY_W'(1);
                        if (flush_q != 2'd0)
                            flush_q <= flush_q - 2'd1;
                        else if (tok_d)
                            run_q <= run_q + RUN_W'(1);
                        else
                            run_q <= '0;
                    end
                end
                LOCKED: begin
                    if (idle_q >= IDLE_MAX) begin
                        state_q <= SEARCH;
                        run_q   <= '0;
                        try_q   <= '0;
                        idle_q  <= '0;
                        flush_q <= '0;
                    end else if (tok_d) begin
                        idle_q <= '0;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
                end
                default: state_q <= SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_pix or posedge rst_in) begin
        if (rst_in) begin
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            data_q <= 8'h00;
        end else if (tok_d) begin
            de_q   <= 1'b0;
            ctrl_q <= tok_ctrl_d;
        end else begin
            de_q   <= 1'b1;
            data_q <= vid_d;
        end
    end

`ifdef TMDS_DEC_TERC4_EN
    logic       t4_hit_d;
    logic [3:0] t4_nib_d;
    logic [3:0] terc4_q;
    logic       terc4_hit_q;

    always_comb begin
        t4_hit_d = 1'b1;
        t4_nib_d = 4'h0;
        case (aw_q)
            10'h29C: t4_nib_d = 4'h0;
            10'h263: t4_nib_d = 4'h1;
            10'h2E4: t4_nib_d = 4'h2;
            10'h2E2: t4_nib_d = 4'h3;
            10'h171: t4_nib_d = 4'h4;
            10'h11E: t4_nib_d = 4'h5;
            10'h18E: t4_nib_d = 4'h6;
            10'h13C: t4_nib_d = 4'h7;
            10'h2CC: t4_nib_d = 4'h8;
            10'h139: t4_nib_d = 4'h9;
            10'h19C: t4_nib_d = 4'hA;
            10'h2C6: t4_nib_d = 4'hB;
            10'h28E: t4_nib_d = 4'hC;
            10'h271: t4_nib_d = 4'hD;
            10'h163: t4_nib_d = 4'hE;
            10'h2C3: t4_nib_d = 4'hF;
            default: t4_hit_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk_pix or posedge rst_in) begin
        if (rst_in) begin
            terc4_q     <= 4'h0;
            terc4_hit_q <= 1'b0;
        end else begin
            terc4_hit_q <= t4_hit_d;
            if (t4_hit_d)
                terc4_q <= t4_nib_d;
        end
    end

    assign terc4     = terc4_q;
    assign terc4_hit = terc4_hit_q;
`else
    assign terc4     = 4'h0;
    assign terc4_hit = 1'b0;
`endif

    assign locked     = (state_q == LOCKED);
    assign bit_offset = off_q;
    assign de         = de_q;
    assign ctrl       = ctrl_q;
    assign data       = data_q;

endmodule

// File: tb/tb_tmds_channel_decoder.sv
// Directed bench for tmds_channel_decoder: reset, acquisition timing, decode table, lock loss and relock.
module tb_tmds_channel_decoder;
    logic       clk_pix = 1'b0;
    logic       rst_in;
    logic [9:0] sym_in;
    logic       locked;
    logic [3:0] bit_offset;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [3:0] terc4;
    logic       terc4_hit;

    tmds_channel_decoder dut (
        .clk_pix   (clk_pix),
        .rst_in    (rst_in),
        .sym_in    (sym_in),
        .locked    (locked),
        .bit_offset(bit_offset),
        .de        (de),
        .ctrl      (ctrl),
        .data      (data),
        .terc4     (terc4),
        .terc4_hit (terc4_hit)
    );

    always #5 clk_pix = ~clk_pix;

`ifdef TMDS_DEC_TERC4_EN
    localparam bit T4_EN = 1'b1;
`else
    localparam bit T4_EN = 1'b0;
`endif

    typedef struct {
        logic [9:0] w;
        logic       de;
        logic [1:0] ctrl;
        logic [7:0] data;
        logic [3:0] t4;
        logic       t4hit;
    } vec_t;

    vec_t       tbl [9];
    int         checks = 0;
    int         passed = 0;
    logic [2:0] prev_hi;
    logic [9:0] tok;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk_pix);
        #1;
    endtask

    // Serialise an aligned word at offset 3: low 7 bits now, top 3 bits next cycle.
    task automatic send(input logic [9:0] w);
        sym_in  = {w[6:0], prev_hi};
        prev_hi = w[9:7];
        tick();
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_locked"}, 32'(locked), 32'd0);
        chk({tag, "_offset"}, 32'(bit_offset), 32'd0);
        chk({tag, "_de"}, 32'(de), 32'd0);
        chk({tag, "_ctrl"}, 32'(ctrl), 32'd0);
        chk({tag, "_data"}, 32'(data), 32'd0);
        chk({tag, "_terc4"}, 32'(terc4), 32'd0);
        chk({tag, "_terc4_hit"}, 32'(terc4_hit), 32'd0);
    endtask

    initial begin
        int n;
        tbl[0] = '{10'h100, 1'b1, 2'b00, 8'h00, 4'h0, 1'b0};
        tbl[1] = '{10'h2FF, 1'b1, 2'b00, 8'hFE, 4'h0, 1'b0};
        tbl[2] = '{10'h0AB, 1'b0, 2'b01, 8'hFE, 4'h0, 1'b0};
        tbl[3] = '{10'h2AB, 1'b0, 2'b11, 8'hFE, 4'h0, 1'b0};
        tbl[4] = '{10'h154, 1'b0, 2'b10, 8'hFE, 4'h0, 1'b0};
        tbl[5] = '{10'h29C, 1'b1, 2'b10, 8'h5B, 4'h0, 1'b1};
        tbl[6] = '{10'h2C3, 1'b1, 2'b10, 8'hBA, 4'hF, 1'b1};
        tbl[7] = '{10'h354, 1'b0, 2'b00, 8'hBA, 4'hF, 1'b0};
        tbl[8] = '{10'h1FF, 1'b1, 2'b00, 8'h01, 4'hF, 1'b0};

        tok     = 10'h354;
        rst_in  = 1'b1;
        sym_in  = '0;
        prev_hi = '0;
        repeat (3) tick();
        chk_reset("por");

        // Lock at offset 5, then reset asynchronously in the middle of a cycle.
        sym_in = {tok[4:0], tok[9:5]};
        rst_in = 1'b0;
        for (int i = 0; i < 150 && !locked; i++) tick();
        chk("off5_locked", 32'(locked), 32'd1);
        chk("off5_offset", 32'(bit_offset), 32'd5);
        #2 rst_in = 1'b1;
        #1 chk_reset("async");

        // Token stream whose word boundary sits at bit 3.
        sym_in = {tok[6:0], tok[9:7]};
        repeat (2) tick();
        rst_in = 1'b0;
        for (int e = 1; e <= 58; e++) begin
            tick();
            if (e == 15) chk("acq_off_e15", 32'(bit_offset), 32'd0);
            if (e == 16) chk("acq_off_e16", 32'(bit_offset), 32'd1);
            if (e == 47) chk("acq_off_e47", 32'(bit_offset), 32'd2);
            if (e == 48) chk("acq_off_e48", 32'(bit_offset), 32'd3);
            if (e == 57) chk("acq_locked_e57", 32'(locked), 32'd0);
            if (e == 58) begin
                chk("acq_locked_e58", 32'(locked), 32'd1);
                chk("acq_de", 32'(de), 32'd0);
                chk("acq_ctrl", 32'(ctrl), 32'd0);
            end
        end

        // Outputs lag the input word by two edges; pad with tokens to drain.
        prev_hi = tok[9:7];
        for (int i = 0; i < 11; i++) begin
            send(i < 9 ? tbl[i].w : tok);
            if (i >= 2) begin
                chk($sformatf("vec%0d_de", i - 2), 32'(de), 32'(tbl[i-2].de));
                chk($sformatf("vec%0d_ctrl", i - 2), 32'(ctrl), 32'(tbl[i-2].ctrl));
                chk($sformatf("vec%0d_data", i - 2), 32'(data), 32'(tbl[i-2].data));
                chk($sformatf("vec%0d_terc4", i - 2), 32'(terc4), 32'(T4_EN ? tbl[i-2].t4 : 4'h0));
                chk($sformatf("vec%0d_hit", i - 2), 32'(terc4_hit), 32'(T4_EN ? tbl[i-2].t4hit : 1'b0));
                chk($sformatf("vec%0d_locked", i - 2), 32'(locked), 32'd1);
            end
        end

        // Video only: lock must drop after the idle timeout, offset kept.
        n = 0;
        while (locked && n < 4300) begin
            send(10'h100);
            n++;
        end
        chk("loss_cycles", 32'(n), 32'd4099);
        chk("loss_locked", 32'(locked), 32'd0);
        chk("loss_offset", 32'(bit_offset), 32'd3);

        n = 0;
        while (!locked && n < 20) begin
            send(tok);
            n++;
        end
        chk("relock_locked", 32'(locked), 32'd1);
        chk("relock_cycles", 32'(n), 32'd10);
        chk("relock_offset", 32'(bit_offset), 32'd3);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
